dsp_mult_acc_drain: RTL and testbench

- Downstream consumer of the DSP multiplier `z_o` product stream (38-bit signed).
- Accumulates groups of `len_i` consecutive products into a wide accumulator.
- Scales each group sum by a rounding arithmetic right shift, then saturates or truncates it to the output width.
- Queues results in a small FIFO with valid/ready output, giving dot-product style post-processing behind `dsp_t1` instances.

---
 rtl/dsp_mult_acc_drain.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_dsp_mult_acc_drain.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mult_acc_drain.sv
// -----------------------------------------------------------------------------
// dsp_mult_acc_drain
//
// Consumes the signed product stream of a DSP multiplier. It sums groups of
// len_i consecutive products in a wide accumulator and scales each group sum
// with a rounding arithmetic right shift. Each sum is then saturated or
// truncated to OUT_WIDTH and queued in a small result FIFO with a valid/ready
// output.
//
// Ports:
//   clock_i      rising-edge clock
//   reset_i      asynchronous active-high reset
//   z_i          signed product (Z_WIDTH)
//   z_valid_i    product valid
//   z_ready_o    block accepts a product this cycle
//   len_i        products per group (0 behaves as 1), sampled on group start
//   shift_i      rounding right-shift amount, sampled on group start
//   saturate_i   1 = saturate, 0 = truncate, sampled on group start
//   res_o        result at FIFO head
//   res_ovf_o    head result saturated or truncated with loss
//   res_valid_o  FIFO non-empty
//   res_ready_i  consumer accepts head
//   busy_o       a group is partially accumulated
//   level_o      FIFO occupancy
// -----------------------------------------------------------------------------
module dsp_mult_acc_drain #(
    parameter int Z_WIDTH    = 38,
    parameter int ACC_WIDTH  = 48,
    parameter int OUT_WIDTH  = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic signed [Z_WIDTH-1:0]       z_i,
    input  logic                            z_valid_i,
    output logic                            z_ready_o,
    input  logic [LEN_WIDTH-1:0]            len_i,
    input  logic [5:0]                      shift_i,
    input  logic                            saturate_i,
    output logic [OUT_WIDTH-1:0]            res_o,
    output logic                            res_ovf_o,
    output logic                            res_valid_o,
    input  logic                            res_ready_i,
    output logic                            busy_o,
    output logic [$clog2(FIFO_DEPTH):0]     level_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int RW    = ACC_WIDTH + 1;
    localparam logic [5:0] SH_MAX = 6'(ACC_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [5:0]             shift_q, shift_d;
    logic                   sat_q, sat_d;
    logic                   pend_q, pend_d;
    logic [ACC_WIDTH-1:0]   post_acc_q, post_acc_d;
    logic [5:0]             post_shift_q, post_shift_d;
    logic                   post_sat_q, post_sat_d;

    logic [OUT_WIDTH:0]     mem_q [FIFO_DEPTH];
    logic [OUT_WIDTH:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;

    // ------------------------------------------------------------------
    // Input-side helpers
    // ------------------------------------------------------------------
    logic [ACC_WIDTH-1:0]   z_ext_s;
    logic [ACC_WIDTH-1:0]   acc_sum_s;
    logic [LEN_WIDTH-1:0]   cnt_inc_s;
    logic [LEN_WIDTH-1:0]   len_eff_s;
    logic [5:0]             shift_clamp_s;
    logic                   z_ready_s;
    logic                   z_acc_s;

    assign z_ext_s       = {{(ACC_WIDTH-Z_WIDTH){z_i[Z_WIDTH-1]}}, z_i};
    assign acc_sum_s     = acc_q + z_ext_s;
    assign cnt_inc_s     = cnt_q + LEN_WIDTH'(1);
    assign len_eff_s     = (len_i == {LEN_WIDTH{1'b0}}) ? LEN_WIDTH'(1) : len_i;
    assign shift_clamp_s = (shift_i > SH_MAX) ? SH_MAX : shift_i;

    // The pending write is counted as occupied so a group finishing now can
    // never find the FIFO full; only registered state feeds this.
    assign z_ready_s = ((level_q + LVL_W'(pend_q)) < LVL_W'(FIFO_DEPTH));
    assign z_acc_s   = z_valid_i && z_ready_s;

    // Group FSM: next state, accumulator, counter and post-stage capture
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        shift_d      = shift_q;
        sat_d        = sat_q;
        pend_d       = 1'b0;
        post_acc_d   = post_acc_q;
        post_shift_d = post_shift_q;
        post_sat_d   = post_sat_q;
        case (state_q)
            ST_IDLE: begin
                if (z_acc_s) begin
                    len_d   = len_eff_s;
                    shift_d = shift_clamp_s;
                    sat_d   = saturate_i;
                    acc_d   = z_ext_s;
                    cnt_d   = LEN_WIDTH'(1);
                    if (len_eff_s <= LEN_WIDTH'(1)) begin
                        // Single-product group completes immediately.
                        pend_d       = 1'b1;
                        post_acc_d   = z_ext_s;
                        post_shift_d = shift_clamp_s;
                        post_sat_d   = saturate_i;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (z_acc_s) begin
                    acc_d = acc_sum_s;
                    if (cnt_inc_s == len_q) begin
                        pend_d       = 1'b1;
                        post_acc_d   = acc_sum_s;
                        post_shift_d = shift_q;
                        post_sat_d   = sat_q;
                        cnt_d        = {LEN_WIDTH{1'b0}};
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_inc_s;
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Group FSM and post-stage registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            acc_q        <= {ACC_WIDTH{1'b0}};
            cnt_q        <= {LEN_WIDTH{1'b0}};
            len_q        <= {LEN_WIDTH{1'b0}};
            shift_q      <= 6'd0;
            sat_q        <= 1'b0;
            pend_q       <= 1'b0;
            post_acc_q   <= {ACC_WIDTH{1'b0}};
            post_shift_q <= 6'd0;
            post_sat_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            shift_q      <= shift_d;
            sat_q        <= sat_d;
            pend_q       <= pend_d;
            post_acc_q   <= post_acc_d;
            post_shift_q <= post_shift_d;
            post_sat_q   <= post_sat_d;
        end
    end

    // ------------------------------------------------------------------
    // Post stage: round, shift, saturate/truncate
    // ------------------------------------------------------------------
    logic signed [RW-1:0]     r_ext_s;
    logic signed [RW-1:0]     round_add_s;
    logic signed [RW-1:0]     r_sum_s;
    logic signed [RW-1:0]     r_shr_s;
    logic [RW-OUT_WIDTH:0]    r_hi_s;
    logic                     r_fits_s;
    logic [OUT_WIDTH-1:0]     post_res_s;
    logic                     post_ovf_s;

    assign r_ext_s = {post_acc_q[ACC_WIDTH-1], post_acc_q};

    // Rounding constant is half an output LSB; one extra bit keeps the add
    // from wrapping, giving round-half-toward-plus-infinity.
    always_comb begin
        round_add_s = {RW{1'b0}};
        if (post_shift_q != 6'd0) begin
            round_add_s = {{(RW-1){1'b0}}, 1'b1} << (post_shift_q - 6'd1);
        end else begin
            round_add_s = {RW{1'b0}};
        end
    end

    assign r_sum_s  = r_ext_s + round_add_s;
    assign r_shr_s  = r_sum_s >>> post_shift_q;
    // Value fits the signed output range when all bits above the output
    // sign bit equal that sign bit.
    assign r_hi_s   = r_shr_s[RW-1:OUT_WIDTH-1];
    assign r_fits_s = (&r_hi_s) | (~|r_hi_s);

    // Saturate or truncate the scaled sum
    always_comb begin
        post_res_s = r_shr_s[OUT_WIDTH-1:0];
        post_ovf_s = ~r_fits_s;
        if (post_sat_q && !r_fits_s) begin
            if (r_shr_s[RW-1]) begin
                post_res_s = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            end else begin
                post_res_s = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
        end else begin
            post_res_s = r_shr_s[OUT_WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic do_pop_s;
    logic do_push_s;

    assign do_pop_s  = (level_q != {LVL_W{1'b0}}) && res_ready_i;
    // Flow control keeps the FIFO from being full here; the guard only
    // protects stored results should that ever be violated.
    assign do_push_s = pend_q && ((level_q != LVL_W'(FIFO_DEPTH)) || do_pop_s);

    // FIFO pointer, level and storage next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = {post_ovf_s, post_res_s};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            level_d = level_q + LVL_W'(1);
        end else if (!do_push_s && do_pop_s) begin
            level_d = level_q - LVL_W'(1);
        end else begin
            level_d = level_q;
        end
    end

    // FIFO registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {(OUT_WIDTH+1){1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ------------------------------------------------------------------
    assign z_ready_o   = z_ready_s;
    assign res_o       = mem_q[rd_ptr_q][OUT_WIDTH-1:0];
    assign res_ovf_o   = mem_q[rd_ptr_q][OUT_WIDTH];
    assign res_valid_o = (level_q != {LVL_W{1'b0}});
    assign busy_o      = (state_q == ST_ACC);
    assign level_o     = level_q;

endmodule

// File: tb/tb_dsp_mult_acc_drain.sv
// -----------------------------------------------------------------------------
// Self-checking bench for dsp_mult_acc_drain. A behavioural group model
// pushes expected {ovf, res} words into a queue as products are accepted;
// a monitor pops and compares them whenever the DUT hands out a result.
// -----------------------------------------------------------------------------
module tb_dsp_mult_acc_drain;

    logic               clock_i;
    logic               reset_i;
    logic signed [37:0] z_i;
    logic               z_valid_i;
    logic               z_ready_o;
    logic [7:0]         len_i;
    logic [5:0]         shift_i;
    logic               saturate_i;
    logic [31:0]        res_o;
    logic               res_ovf_o;
    logic               res_valid_o;
    logic               res_ready_i;
    logic               busy_o;
    logic [2:0]         level_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] sb_q [$];

    // group model state
    int     m_cnt = 0;
    int     m_len = 1;
    int     m_sh  = 0;
    bit     m_sat = 1'b0;
    longint m_sum = 0;

    dsp_mult_acc_drain dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .z_i         (z_i),
        .z_valid_i   (z_valid_i),
        .z_ready_o   (z_ready_o),
        .len_i       (len_i),
        .shift_i     (shift_i),
        .saturate_i  (saturate_i),
        .res_o       (res_o),
        .res_ovf_o   (res_ovf_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .busy_o      (busy_o),
        .level_o     (level_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference scaling: round half up, arithmetic shift, clamp/truncate.
    function automatic logic [32:0] model_res(input longint sum, input int sh_in, input bit sat);
        int     sh;
        longint r;
        bit     ovf;
        logic [31:0] res;
        sh = (sh_in > 47) ? 47 : sh_in;
        r  = sum + ((sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0);
        r  = r >>> sh;
        ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        if (sat && ovf) res = (r < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else            res = r[31:0];
        return {ovf, res};
    endfunction

    // Model: observe products that will be accepted on the coming edge
    always @(negedge clock_i) begin
        if (!reset_i && z_valid_i && z_ready_o) begin
            if (m_cnt == 0) begin
                m_len = (len_i == 8'd0) ? 1 : int'(len_i);
                m_sh  = int'(shift_i);
                m_sat = saturate_i;
                m_sum = longint'(z_i);
            end else begin
                m_sum = m_sum + longint'(z_i);
            end
            m_cnt++;
            if (m_cnt >= m_len) begin
                sb_q.push_back(model_res(m_sum, m_sh, m_sat));
                m_cnt = 0;
            end
        end
    end

    // Scoreboard: compare each result the consumer takes on the coming edge
    always @(negedge clock_i) begin
        logic [32:0] exp_w;
        if (!reset_i && res_valid_o && res_ready_i) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_result", {31'd0, res_ovf_o, res_o}, 64'd0);
            end else begin
                exp_w = sb_q.pop_front();
                check_eq("res", {32'd0, res_o}, {32'd0, exp_w[31:0]});
                check_eq("ovf", {63'd0, res_ovf_o}, {63'd0, exp_w[32]});
            end
        end
    end

    // Offer one product and hold it until accepted (bounded wait).
    task automatic send(input longint z, input logic [7:0] len, input logic [5:0] sh, input bit sat);
        int waited;
        waited     = 0;
        z_i        = z[37:0];
        len_i      = len;
        shift_i    = sh;
        saturate_i = sat;
        z_valid_i  = 1'b1;
        forever begin
            @(negedge clock_i);
            if (z_ready_o) begin
                @(posedge clock_i);
                #1;
                z_valid_i = 1'b0;
                return;
            end else begin
                waited++;
                if (waited > 200) begin
                    check_eq("send_timeout", 64'd1, 64'd0);
                    z_valid_i = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clock_i);
        #1;
    endtask

    // Wait until every expected result has been consumed (bounded).
    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while ((sb_q.size() != 0 || res_valid_o) && cyc < 200) begin
            @(posedge clock_i);
            #1;
            cyc++;
        end
        check_eq(tag, sb_q.size(), 64'd0);
    endtask

    initial begin
        int k;
        logic rdy;
        reset_i     = 1'b1;
        z_i         = '0;
        z_valid_i   = 1'b0;
        len_i       = 8'd1;
        shift_i     = 6'd0;
        saturate_i  = 1'b1;
        res_ready_i = 1'b0;
        idle_cycles(3);

        // reset state
        check_eq("rst_z_ready", {63'd0, z_ready_o}, 64'd1);
        check_eq("rst_valid", {63'd0, res_valid_o}, 64'd0);
        check_eq("rst_level", {61'd0, level_o}, 64'd0);
        check_eq("rst_busy", {63'd0, busy_o}, 64'd0);
        check_eq("rst_res", {31'd0, res_ovf_o, res_o}, 64'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        idle_cycles(1);

        // 1: len=1 back-to-back, latency check
        res_ready_i = 1'b1;
        send(5, 8'd1, 6'd0, 1'b1);
        check_eq("lat_pend_not_valid", {63'd0, res_valid_o}, 64'd0);
        send(-7, 8'd1, 6'd0, 1'b1);
        check_eq("lat_valid", {63'd0, res_valid_o}, 64'd1);
        send(123456, 8'd1, 6'd0, 1'b1);
        drain("t1_drain");

        // 2: len=4 with gaps, rounding shift
        send(100, 8'd4, 6'd2, 1'b1);
        check_eq("t2_busy_mid", {63'd0, busy_o}, 64'd1);
        idle_cycles(2);
        send(200, 8'd4, 6'd2, 1'b1);
        idle_cycles(1);
        send(300, 8'd4, 6'd2, 1'b1);
        check_eq("t2_busy_mid2", {63'd0, busy_o}, 64'd1);
        idle_cycles(3);
        send(401, 8'd4, 6'd2, 1'b1);
        check_eq("t2_busy_done", {63'd0, busy_o}, 64'd0);
        drain("t2_drain");
        check_eq("t2_model_250", {31'd0, model_res(64'sd1001, 2, 1'b1)}, 64'd250);

        // 3: overflow, saturate then truncate
        send(64'sd1 <<< 36, 8'd2, 6'd0, 1'b1);
        send(64'sd1 <<< 36, 8'd2, 6'd0, 1'b1);
        send(64'sd1 <<< 36, 8'd2, 6'd0, 1'b0);
        send(64'sd1 <<< 36, 8'd2, 6'd0, 1'b0);
        // negative saturation, len=0 acting as 1, shift clamp
        send(-(64'sd1 <<< 37), 8'd0, 6'd0, 1'b1);
        send(7, 8'd0, 6'd1, 1'b1);
        send(-(64'sd1 <<< 37), 8'd1, 6'd63, 1'b0);
        drain("t3_drain");

        // 4: consumer stalled, FIFO fills to exactly 4
        res_ready_i = 1'b0;
        len_i       = 8'd1;
        shift_i     = 6'd0;
        saturate_i  = 1'b1;
        k           = 0;
        for (int i = 0; i < 10; i++) begin
            z_i       = 38'(1000 + k);
            z_valid_i = 1'b1;
            @(negedge clock_i);
            rdy = z_ready_o;
            check_eq("t4_level_bound", {63'd0, (level_o <= 3'd4)}, 64'd1);
            @(posedge clock_i);
            #1;
            if (rdy) k++;
        end
        z_valid_i = 1'b0;
        check_eq("t4_accepted", k, 64'd4);
        check_eq("t4_level_full", {61'd0, level_o}, 64'd4);
        check_eq("t4_z_ready_low", {63'd0, z_ready_o}, 64'd0);
        res_ready_i = 1'b1;
        for (int i = k; i < 10; i++) send(1000 + i, 8'd1, 6'd0, 1'b1);
        drain("t4_drain");

        // 6: level 3 plus pending write, pop on the write edge
        res_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(-50 - i, 8'd1, 6'd0, 1'b0);
        check_eq("t6_level_pre", {61'd0, level_o}, 64'd3);
        res_ready_i = 1'b1;
        idle_cycles(1);
        check_eq("t6_level_pushpop", {61'd0, level_o}, 64'd3);
        drain("t6_drain");

        // 5: reset in the middle of a len=8 group
        send(111111, 8'd8, 6'd4, 1'b0);
        send(222222, 8'd8, 6'd4, 1'b0);
        send(333333, 8'd8, 6'd4, 1'b0);
        check_eq("t5_busy_before", {63'd0, busy_o}, 64'd1);
        #2;
        reset_i = 1'b1;
        sb_q.delete();
        m_cnt = 0;
        #1;
        check_eq("t5_rst_busy", {63'd0, busy_o}, 64'd0);
        check_eq("t5_rst_level", {61'd0, level_o}, 64'd0);
        check_eq("t5_rst_z_ready", {63'd0, z_ready_o}, 64'd1);
        check_eq("t5_rst_valid", {63'd0, res_valid_o}, 64'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        idle_cycles(1);
        send(-3000, 8'd8, 6'd4, 1'b0);
        send(5, 8'd8, 6'd4, 1'b0);
        send(77777, 8'd8, 6'd4, 1'b0);
        send(-1, 8'd8, 6'd4, 1'b0);
        send(64'sd1 <<< 30, 8'd8, 6'd4, 1'b0);
        send(-12345, 8'd8, 6'd4, 1'b0);
        send(999, 8'd8, 6'd4, 1'b0);
        send(42, 8'd8, 6'd4, 1'b0);
        drain("t5_drain");
        idle_cycles(2);
        check_eq("final_level", {61'd0, level_o}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
